alto_disk_seq: RTL and testbench

ALTO_DISK_SEQ -- requirements
Module: alto_disk_seq

---
 rtl/alto_disk_seq_pkg.sv | 47 ++++
 rtl/alto_disk_sector_timer.sv | 37 +++
 rtl/alto_disk_seq.sv | 196 +++++++++++++++++++
 tb/tb_alto_disk_seq.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alto_disk_seq_pkg.sv
// rtl/alto_disk_seq_pkg.sv - shared alto definitions: task, F1, F2, BS codes and seek FSM states
package alto_disk_seq_pkg;

    // Microtask number of the disk-sector task
    localparam logic [3:0] TASK_KSEC = 4'd4;

    // F1 codes honoured while the disk-sector task runs
    localparam logic [3:0] F1_NOP        = 4'd0;
    localparam logic [3:0] F1_BLOCK      = 4'd3;
    localparam logic [3:0] F1_STROBE     = 4'd9;
    localparam logic [3:0] F1_KSTAT_LOAD = 4'd10;
    localparam logic [3:0] F1_INCRECNO   = 4'd11;
    localparam logic [3:0] F1_CLRSTAT    = 4'd12;
    localparam logic [3:0] F1_KCOMM_LOAD = 4'd13;
    localparam logic [3:0] F1_KADR_LOAD  = 4'd14;
    localparam logic [3:0] F1_KDATA_LOAD = 4'd15;

    // F2 codes producing next-address modifiers
    localparam logic [3:0] F2_NOP     = 4'd0;
    localparam logic [3:0] F2_RWC     = 4'd9;
    localparam logic [3:0] F2_RECNO   = 4'd10;
    localparam logic [3:0] F2_XFRDAT  = 4'd11;
    localparam logic [3:0] F2_SWRNRDY = 4'd12;
    localparam logic [3:0] F2_NFER    = 4'd13;
    localparam logic [3:0] F2_STROBON = 4'd14;

    // Bus source codes
    localparam logic [2:0] BS_NONE  = 3'd0;
    localparam logic [2:0] BS_KSTAT = 3'd3;
    localparam logic [2:0] BS_KDAT  = 3'd4;

    typedef enum logic {
        SEEK_IDLE = 1'b0,
        SEEK_STEP = 1'b1
    } seek_state_t;

    // Record counter to the record-number dispatch order 0,2,3,1
    function automatic logic [1:0] recno_map(input logic [1:0] r);
        case (r)
            2'd0:    recno_map = 2'd0;
            2'd1:    recno_map = 2'd2;
            2'd2:    recno_map = 2'd3;
            default: recno_map = 2'd1;
        endcase
    endfunction

endpackage

// File: rtl/alto_disk_sector_timer.sv
// rtl/alto_disk_sector_timer.sv - free-running sector timer with sector counter
// Ports: clk, rst (async, active-high); sector = current sector number;
//        pulse = one-cycle strobe on the cycle the timer reaches zero.
module alto_disk_sector_timer
    import alto_disk_seq_pkg::*;
#(
    parameter int NUM_SECTORS   = 12,
    parameter int SECTOR_CYCLES = 12250
) (
    input  logic       clk,
    input  logic       rst,
    output logic [3:0] sector,
    output logic       pulse
);

    localparam int             TW     = $clog2(SECTOR_CYCLES + 1);
    localparam logic [TW-1:0]  RELOAD = TW'(SECTOR_CYCLES - 1);
    localparam logic [3:0]     LAST   = 4'(NUM_SECTORS - 1);

    logic [TW-1:0] timer;

    // Timer resets to zero, so the first pulse lands on the first clock after reset
    assign pulse = (timer == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer  <= '0;
            sector <= '0;
        end else if (pulse) begin
            timer  <= RELOAD;
            sector <= (sector == LAST) ? 4'd0 : sector + 4'd1;
        end else begin
            timer <= timer - TW'(1);
        end
    end

endmodule

// File: rtl/alto_disk_seq.sv
// rtl/alto_disk_seq.sv - Alto disk-sector task sequencer: sector timing, seek FSM, KSTAT/modifiers
// Ports: clk_i, rst_i (async, active-high); current_task_i, bs_i, f1_i, f2_i = microinstruction;
//        bus_i = bus write data; bus_o = KSTAT/KDAT read data (16'hFFFF idle);
//        modifiers_o = next-address OR bits; sector_req_o = disk-sector task wakeup.
// Option: ALTO_DISK_SEQ_WATCHDOG_EN - a sector pulse while sector_req_o is still set raises data_late.
module alto_disk_seq
    import alto_disk_seq_pkg::*;
#(
    parameter int NUM_DRIVES       = 2,
    parameter int NUM_SECTORS      = 12,
    parameter int SECTOR_CYCLES    = 12250,
    parameter int SEEK_STEP_CYCLES = 64,
    parameter int MAX_CYL          = 202
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [3:0]  current_task_i,
    input  logic [2:0]  bs_i,
    input  logic [3:0]  f1_i,
    input  logic [3:0]  f2_i,
    input  logic [15:0] bus_i,
    output logic [15:0] bus_o,
    output logic [9:0]  modifiers_o,
    output logic        sector_req_o
);

    localparam int            SW          = $clog2(SEEK_STEP_CYCLES + 1);
    localparam logic [SW-1:0] STEP_RELOAD = SW'(SEEK_STEP_CYCLES - 1);
    localparam logic [8:0]    MAXC        = 9'(MAX_CYL);
    localparam logic [2:0]    ND          = 3'(NUM_DRIVES);

    seek_state_t   state, state_nxt;
    logic [8:0]    cyl [NUM_DRIVES];
    logic [1:0]    drive;
    logic [8:0]    target;
    logic [SW-1:0] step_cnt;
    logic [15:0]   kdata;
    logic [7:0]    kadr;
    logic [1:0]    recno;
    logic          xferoff, wdinhib, bclksrc, wffo, sendaddr;
    logic          seek_fail, data_late, checksum_error;
    logic [1:0]    completion_code;

    logic [3:0]    sector;
    logic          sector_pulse;

    logic          ksec, seek, idle, not_rdy;
    logic [8:0]    cur_cyl, new_cyl, cyl_next, new_target;
    logic          new_bad, step_tick, seek_req;
    logic [1:0]    rwc;
    logic [15:0]   kstat;

    alto_disk_sector_timer #(
        .NUM_SECTORS  (NUM_SECTORS),
        .SECTOR_CYCLES(SECTOR_CYCLES)
    ) u_sector_timer (
        .clk   (clk_i),
        .rst   (rst_i),
        .sector(sector),
        .pulse (sector_pulse)
    );

    assign ksec       = (current_task_i == TASK_KSEC);
    assign seek       = (state == SEEK_STEP);
    assign idle       = (state == SEEK_IDLE);
    assign not_rdy    = ({1'b0, drive} >= ND);
    assign new_target = kdata[12:4];
    assign new_bad    = (new_target > MAXC) || ({1'b0, kdata[15:14]} >= ND);
    assign step_tick  = seek && (step_cnt == '0);
    assign seek_req   = idle && ksec && (f1_i == F1_STROBE) && sendaddr;
    assign cyl_next   = (cur_cyl < target) ? cur_cyl + 9'd1 : cur_cyl - 9'd1;
    assign rwc        = kadr[7] ? 2'd3 : (kadr[6] ? 2'd2 : 2'd0);
    assign kstat      = {sector, 4'hF, seek_fail, seek, not_rdy, data_late,
                         idle, checksum_error, completion_code};

    // Cylinder of the latched drive (stepping) and of the drive named in kdata (new strobe)
    always_comb begin
        cur_cyl = '0;
        new_cyl = '0;
        for (int i = 0; i < NUM_DRIVES; i++) begin
            if (drive == 2'(i))        cur_cyl = cyl[i];
            if (kdata[15:14] == 2'(i)) new_cyl = cyl[i];
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            SEEK_IDLE: if (seek_req && !new_bad && (new_target != new_cyl)) state_nxt = SEEK_STEP;
            SEEK_STEP: if (step_tick && (cyl_next == target))               state_nxt = SEEK_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state           <= SEEK_IDLE;
            for (int i = 0; i < NUM_DRIVES; i++) cyl[i] <= '0;
            drive           <= '0;
            target          <= '0;
            step_cnt        <= '0;
            kdata           <= '0;
            kadr            <= '0;
            recno           <= '0;
            xferoff         <= 1'b1;
            wdinhib         <= 1'b1;
            bclksrc         <= 1'b0;
            wffo            <= 1'b0;
            sendaddr        <= 1'b0;
            seek_fail       <= 1'b0;
            data_late       <= 1'b0;
            checksum_error  <= 1'b0;
            completion_code <= '0;
            sector_req_o    <= 1'b0;
        end else begin
            state <= state_nxt;

            if (ksec) begin
                case (f1_i)
                    F1_KSTAT_LOAD: {checksum_error, completion_code} <= bus_i[2:0];
                    F1_INCRECNO: begin
                        kadr  <= {kadr[5:0], 2'b00};
                        recno <= recno + 2'd1;
                    end
                    F1_CLRSTAT: begin
                        seek_fail       <= 1'b0;
                        data_late       <= 1'b0;
                        checksum_error  <= 1'b0;
                        completion_code <= '0;
                    end
                    F1_KCOMM_LOAD: {xferoff, wdinhib, bclksrc, wffo, sendaddr} <= bus_i[14:10];
                    F1_KADR_LOAD: begin
                        kadr  <= bus_i[7:0];
                        recno <= '0;
                    end
                    F1_KDATA_LOAD: kdata <= bus_i;
                    default: ;
                endcase
            end

            // Wakeup: a new sector beats a coincident BLOCK
            if (sector_pulse)
                sector_req_o <= 1'b1;
            else if (ksec && (f1_i == F1_BLOCK))
                sector_req_o <= 1'b0;

`ifdef ALTO_DISK_SEQ_WATCHDOG_EN
            if (sector_pulse && sector_req_o) data_late <= 1'b1;
`endif

            if (seek_req) begin
                drive    <= kdata[15:14];
                target   <= new_target;
                step_cnt <= STEP_RELOAD;
                if (new_bad) seek_fail <= 1'b1;
            end

            if (seek) begin
                if (step_cnt == '0) begin
                    step_cnt <= STEP_RELOAD;
                    for (int i = 0; i < NUM_DRIVES; i++)
                        if (drive == 2'(i)) cyl[i] <= cyl_next;
                end else begin
                    step_cnt <= step_cnt - SW'(1);
                end
            end
        end
    end

    always_comb begin
        bus_o = 16'hFFFF;
        if (ksec) begin
            if (bs_i == BS_KSTAT)     bus_o = kstat;
            else if (bs_i == BS_KDAT) bus_o = 16'h0000;
        end
    end

    always_comb begin
        modifiers_o = '0;
        if (ksec) begin
            case (f2_i)
                F2_RWC:     modifiers_o = {8'd0, rwc};
                F2_RECNO:   modifiers_o = {8'd0, recno_map(recno)};
                F2_XFRDAT:  modifiers_o = {9'd0, ~kadr[1]};
                F2_SWRNRDY: modifiers_o = {9'd0, seek | not_rdy};
                F2_NFER:    modifiers_o = {9'd0, not_rdy | data_late | seek_fail};
                F2_STROBON: modifiers_o = {9'd0, seek};
                default:    ;
            endcase
        end
    end

    // Command bits with no consumer inside this block
    logic unused_bits;
    assign unused_bits = ^{xferoff, wdinhib, bclksrc, wffo, kdata[13], kdata[3:0]};

endmodule

// File: tb/tb_alto_disk_seq.sv
// tb/tb_alto_disk_seq.sv - directed self-checking bench for alto_disk_seq
module tb_alto_disk_seq;
    import alto_disk_seq_pkg::*;

`ifdef ALTO_DISK_SEQ_WATCHDOG_EN
    localparam logic WD = 1'b1;
`else
    localparam logic WD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  current_task;
    logic [2:0]  bs;
    logic [3:0]  f1, f2;
    logic [15:0] bus_in, bus_out;
    logic [9:0]  modifiers;
    logic        sector_req;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic [9:0] m;

    alto_disk_seq #(
        .NUM_DRIVES      (2),
        .NUM_SECTORS     (4),
        .SECTOR_CYCLES   (10),
        .SEEK_STEP_CYCLES(64),
        .MAX_CYL         (202)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .current_task_i(current_task),
        .bs_i          (bs),
        .f1_i          (f1),
        .f2_i          (f2),
        .bus_i         (bus_in),
        .bus_o         (bus_out),
        .modifiers_o   (modifiers),
        .sector_req_o  (sector_req)
    );

    always #5 clk = ~clk;

    // Edge count since reset release: pulses land on edges 1, 11, 21, ...
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] f1v, input logic [15:0] busv);
        f1 = f1v;
        bus_in = busv;
        step();
        f1 = F1_NOP;
        bus_in = 16'h0000;
    endtask

    // Return with the next clock edge being one whose index mod 10 equals r
    task automatic align(input int r);
        for (int i = 0; i < 10; i++) begin
            if ((cyc + 1) % 10 == r) break;
            step();
        end
    endtask

    task automatic mod_of(input logic [3:0] f2v, output logic [9:0] mv);
        f2 = f2v;
        #1;
        mv = modifiers;
        f2 = F2_NOP;
    endtask

    task automatic test_reset();
        step();
        step();
        n_checks++;
        if (bus_out !== 16'h0F08) begin n_fail++; $display("FAIL reset_kstat: got %h want 0f08", bus_out); end
        n_checks++;
        if (sector_req !== 1'b0) begin n_fail++; $display("FAIL reset_sector_req: got %b want 0", sector_req); end
        mod_of(F2_XFRDAT, m);
        n_checks++;
        if (m !== 10'd1) begin n_fail++; $display("FAIL reset_xfrdat: got %0d want 1", m); end
        current_task = 4'd0;
        #1;
        n_checks++;
        if (bus_out !== 16'hFFFF) begin n_fail++; $display("FAIL other_task_bus: got %h want ffff", bus_out); end
        current_task = TASK_KSEC;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if (sector_req !== 1'b0) begin n_fail++; $display("FAIL release_sector_req: got %b want 0", sector_req); end
    endtask

    task automatic test_sector();
        step();
        n_checks++;
        if (sector_req !== 1'b1) begin n_fail++; $display("FAIL first_pulse_req: got %b want 1", sector_req); end
        n_checks++;
        if (bus_out[15:12] !== 4'd1) begin n_fail++; $display("FAIL sector_1: got %0d want 1", bus_out[15:12]); end
        repeat (10) step();
        n_checks++;
        if (bus_out[15:12] !== 4'd2) begin n_fail++; $display("FAIL sector_2: got %0d want 2", bus_out[15:12]); end
        repeat (10) step();
        n_checks++;
        if (bus_out[15:12] !== 4'd3) begin n_fail++; $display("FAIL sector_3: got %0d want 3", bus_out[15:12]); end
        repeat (9) step();
        n_checks++;
        if (bus_out[15:12] !== 4'd3) begin n_fail++; $display("FAIL sector_hold: got %0d want 3", bus_out[15:12]); end
        step();
        n_checks++;
        if (bus_out[15:12] !== 4'd0) begin n_fail++; $display("FAIL sector_wrap: got %0d want 0", bus_out[15:12]); end
        n_checks++;
        if (bus_out[4] !== WD) begin n_fail++; $display("FAIL unserviced_late: got %b want %b", bus_out[4], WD); end
    endtask

    task automatic test_block();
        align(5);
        issue(F1_BLOCK, 16'h0000);
        n_checks++;
        if (sector_req !== 1'b0) begin n_fail++; $display("FAIL block_clears: got %b want 0", sector_req); end
        issue(F1_CLRSTAT, 16'h0000);
        n_checks++;
        if (bus_out[4] !== 1'b0) begin n_fail++; $display("FAIL clrstat_late: got %b want 0", bus_out[4]); end
        align(2);
        n_checks++;
        if (sector_req !== 1'b1 || bus_out[4] !== 1'b0) begin
            n_fail++; $display("FAIL serviced_pulse: req %b late %b want 1 0", sector_req, bus_out[4]);
        end
        align(1);
        issue(F1_BLOCK, 16'h0000);
        n_checks++;
        if (sector_req !== 1'b1) begin n_fail++; $display("FAIL block_vs_pulse: got %b want 1", sector_req); end
        n_checks++;
        if (bus_out[4] !== WD) begin n_fail++; $display("FAIL coincident_late: got %b want %b", bus_out[4], WD); end
    endtask

    task automatic test_kadr_recno();
        issue(F1_KADR_LOAD, 16'h0042);
        mod_of(F2_RWC, m);
        n_checks++;
        if (m !== 10'd2) begin n_fail++; $display("FAIL rwc_01: got %0d want 2", m); end
        mod_of(F2_XFRDAT, m);
        n_checks++;
        if (m !== 10'd0) begin n_fail++; $display("FAIL xfrdat_0: got %0d want 0", m); end
        mod_of(F2_RECNO, m);
        n_checks++;
        if (m !== 10'd0) begin n_fail++; $display("FAIL recno_0: got %0d want 0", m); end
        issue(F1_INCRECNO, 16'h0000);
        mod_of(F2_RECNO, m);
        n_checks++;
        if (m !== 10'd2) begin n_fail++; $display("FAIL recno_1: got %0d want 2", m); end
        mod_of(F2_XFRDAT, m);
        n_checks++;
        if (m !== 10'd1) begin n_fail++; $display("FAIL xfrdat_1: got %0d want 1", m); end
        issue(F1_INCRECNO, 16'h0000);
        mod_of(F2_RECNO, m);
        n_checks++;
        if (m !== 10'd3) begin n_fail++; $display("FAIL recno_2: got %0d want 3", m); end
        issue(F1_INCRECNO, 16'h0000);
        mod_of(F2_RECNO, m);
        n_checks++;
        if (m !== 10'd1) begin n_fail++; $display("FAIL recno_3: got %0d want 1", m); end
        mod_of(F2_RWC, m);
        n_checks++;
        if (m !== 10'd3) begin n_fail++; $display("FAIL rwc_1x: got %0d want 3", m); end
        issue(F1_KSTAT_LOAD, 16'h0005);
        n_checks++;
        if (bus_out[2:0] !== 3'd5) begin n_fail++; $display("FAIL kstat_load: got %0d want 5", bus_out[2:0]); end
        current_task = 4'd0;
        issue(F1_KSTAT_LOAD, 16'h0002);
        current_task = TASK_KSEC;
        #1;
        n_checks++;
        if (bus_out[2:0] !== 3'd5) begin n_fail++; $display("FAIL other_task_f1: got %0d want 5", bus_out[2:0]); end
        issue(F1_CLRSTAT, 16'h0000);
        n_checks++;
        if (bus_out[2:0] !== 3'd0) begin n_fail++; $display("FAIL clrstat_low: got %0d want 0", bus_out[2:0]); end
    endtask

    task automatic test_seek();
        issue(F1_KDATA_LOAD, 16'h0050);
        issue(F1_KCOMM_LOAD, 16'h0400);
        issue(F1_STROBE, 16'h0000);
        n_checks++;
        if (bus_out[6] !== 1'b1 || bus_out[3] !== 1'b0) begin
            n_fail++; $display("FAIL seek_start: seek %b idle %b want 1 0", bus_out[6], bus_out[3]);
        end
        mod_of(F2_STROBON, m);
        n_checks++;
        if (m !== 10'd1) begin n_fail++; $display("FAIL strobon: got %0d want 1", m); end
        for (int k = 1; k < 320; k++) begin
            if (k == 100)      issue(F1_KDATA_LOAD, 16'h0070);
            else if (k == 101) issue(F1_STROBE, 16'h0000);
            else if (k == 102) issue(F1_CLRSTAT, 16'h0000);
            else               step();
        end
        n_checks++;
        if (bus_out[6] !== 1'b1) begin n_fail++; $display("FAIL seek_319: got %b want 1", bus_out[6]); end
        step();
        n_checks++;
        if (bus_out[6] !== 1'b0 || bus_out[3] !== 1'b1) begin
            n_fail++; $display("FAIL seek_done: seek %b idle %b want 0 1", bus_out[6], bus_out[3]);
        end
        issue(F1_KDATA_LOAD, 16'h0050);
        issue(F1_STROBE, 16'h0000);
        n_checks++;
        if (bus_out[6] !== 1'b0) begin n_fail++; $display("FAIL same_cyl: got %b want 0", bus_out[6]); end
        issue(F1_KDATA_LOAD, 16'h0030);
        issue(F1_STROBE, 16'h0000);
        repeat (127) step();
        n_checks++;
        if (bus_out[6] !== 1'b1) begin n_fail++; $display("FAIL down_127: got %b want 1", bus_out[6]); end
        step();
        n_checks++;
        if (bus_out[6] !== 1'b0) begin n_fail++; $display("FAIL down_128: got %b want 0", bus_out[6]); end
    endtask

    task automatic test_seek_fail();
        issue(F1_KDATA_LOAD, 16'h12C0);
        issue(F1_STROBE, 16'h0000);
        n_checks++;
        if (bus_out[7] !== 1'b1 || bus_out[6] !== 1'b0) begin
            n_fail++; $display("FAIL bad_target: fail %b seek %b want 1 0", bus_out[7], bus_out[6]);
        end
        mod_of(F2_NFER, m);
        n_checks++;
        if (m !== 10'd1) begin n_fail++; $display("FAIL nfer_set: got %0d want 1", m); end
        align(5);
        issue(F1_BLOCK, 16'h0000);
        issue(F1_CLRSTAT, 16'h0000);
        n_checks++;
        if (bus_out[7] !== 1'b0) begin n_fail++; $display("FAIL clr_seek_fail: got %b want 0", bus_out[7]); end
        mod_of(F2_NFER, m);
        n_checks++;
        if (m !== 10'd0) begin n_fail++; $display("FAIL nfer_clear: got %0d want 0", m); end
        issue(F1_KDATA_LOAD, 16'h0030);
        issue(F1_STROBE, 16'h0000);
        n_checks++;
        if (bus_out[6] !== 1'b0) begin n_fail++; $display("FAIL cyl_unchanged: got %b want 0", bus_out[6]); end
    endtask

    task automatic test_drive();
        issue(F1_KDATA_LOAD, 16'hC050);
        issue(F1_STROBE, 16'h0000);
        n_checks++;
        if (bus_out[5] !== 1'b1) begin n_fail++; $display("FAIL not_rdy: got %b want 1", bus_out[5]); end
        mod_of(F2_SWRNRDY, m);
        n_checks++;
        if (m !== 10'd1) begin n_fail++; $display("FAIL swrnrdy: got %0d want 1", m); end
        issue(F1_KDATA_LOAD, 16'h4000);
        issue(F1_STROBE, 16'h0000);
        n_checks++;
        if (bus_out[5] !== 1'b0 || bus_out[6] !== 1'b0) begin
            n_fail++; $display("FAIL drive1: not_rdy %b seek %b want 0 0", bus_out[5], bus_out[6]);
        end
        bs = BS_KDAT;
        #1;
        n_checks++;
        if (bus_out !== 16'h0000) begin n_fail++; $display("FAIL kdat_read: got %h want 0000", bus_out); end
        bs = BS_KSTAT;
    endtask

    task automatic test_reset_mid_seek();
        issue(F1_KDATA_LOAD, 16'h0640);
        issue(F1_STROBE, 16'h0000);
        repeat (50) step();
        n_checks++;
        if (bus_out[6] !== 1'b1) begin n_fail++; $display("FAIL long_seek: got %b want 1", bus_out[6]); end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus_out !== 16'h0F08) begin n_fail++; $display("FAIL async_reset_kstat: got %h want 0f08", bus_out); end
        n_checks++;
        if (sector_req !== 1'b0) begin n_fail++; $display("FAIL async_reset_req: got %b want 0", sector_req); end
        @(negedge clk);
        rst = 1'b0;
        issue(F1_KCOMM_LOAD, 16'h0400);
        issue(F1_KDATA_LOAD, 16'h0000);
        issue(F1_STROBE, 16'h0000);
        n_checks++;
        if (bus_out[6] !== 1'b0) begin n_fail++; $display("FAIL cyl_reset: got %b want 0", bus_out[6]); end
    endtask

    initial begin
        current_task = TASK_KSEC;
        bs           = BS_KSTAT;
        f1           = F1_NOP;
        f2           = F2_NOP;
        bus_in       = 16'h0000;
        test_reset();
        test_sector();
        test_block();
        test_kadr_recno();
        test_seek();
        test_seek_fail();
        test_drive();
        test_reset_mid_seek();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
